// File: rtl/bpi_pkg.sv
// Shared constants and status-word layout for the BPI FIFO/status stage.
package bpi_pkg;
   localparam int BPI_DW     = 16;
   localparam int BPI_CMD_AW = 10;
   localparam int BPI_RBK_AW = 10;

   localparam logic [31:0] TIMER_MAX = 32'hFFFF_FFFF;

   localparam int ST_RBK_ERR   = 0;
   localparam int ST_CMD_OVF   = 1;
   localparam int ST_RBK_EMPTY = 2;
   localparam int ST_RBK_FULL  = 3;
   localparam int ST_CMD_EMPTY = 4;
   localparam int ST_CMD_FULL  = 5;
   localparam int ST_BUSY      = 6;
   localparam int ST_ENBL      = 7;
   localparam int ST_FLASH_LSB = 8;

   // Field order matches the ST_* bit indices above.
   typedef struct packed {
      logic [7:0] flash_sr;
      logic       enbl;
      logic       busy;
      logic       cmd_full;
      logic       cmd_empty;
      logic       rbk_full;
      logic       rbk_empty;
      logic       cmd_ovf;
      logic       rbk_err;
   } bpi_status_t;
endpackage

// File: rtl/bpi_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with registered occupancy count.
module bpi_sync_fifo_fwft #(
   parameter int DW            = 16,
   parameter int AW            = 10,
   parameter bit PUSH_FULL_POP = 1'b0  // accept a push into a full FIFO when a pop happens too
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          clr,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          ovf,
   output logic          unf
);
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW-1:0] PTR_ONE = 1;

   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign empty     = (count == '0);
   assign full      = count[AW];
   assign do_pop    = pop & ~empty;
   assign do_push   = push & (~full | (PUSH_FULL_POP & do_pop));
   assign ovf       = push & ~do_push;
   assign unf       = pop & empty;
   assign head_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge CLK)
      if (do_push && !clr) mem[wr_ptr] <= push_data;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/bpi_fifo_ctrl.sv
// Command/readback buffering, parse enable, status word and operation timer
// sitting between the VME BPI port and the command-parsing engine.
module bpi_fifo_ctrl
   import bpi_pkg::*;
#(
   parameter int DW     = BPI_DW,
   parameter int CMD_AW = BPI_CMD_AW,
   parameter int RBK_AW = BPI_RBK_AW
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              BPI_RST,
   input  logic              BPI_DSBL,
   input  logic              BPI_ENBL,
   input  logic              BPI_WE,
   input  logic [DW-1:0]     BPI_CMD_FIFO_DATA,
   input  logic              BPI_RE,
   output logic [DW-1:0]     BPI_RBK_FIFO_DATA,
   output logic [RBK_AW:0]   BPI_RBK_WRD_CNT,
   output logic [15:0]       BPI_STATUS,
   output logic [31:0]       BPI_TIMER,
   output logic              CMD_VALID,
   output logic [DW-1:0]     CMD_DATA,
   input  logic              CMD_ACK,
   input  logic              RBK_WE,
   input  logic [DW-1:0]     RBK_DATA,
   input  logic              ENGINE_BUSY,
   input  logic [7:0]        FLASH_SR
);
   logic              enable;
   logic              cmd_full, cmd_empty, cmd_ovf, cmd_unf, cmd_pop;
   logic [CMD_AW:0]   cmd_cnt;
   logic              rbk_full, rbk_empty, rbk_ovf, rbk_unf;
   logic              cmd_ovf_st, rbk_ovf_st, rbk_unf_st;
   logic [31:0]       timer;
   bpi_status_t       status_q;
   logic              unused_cmd;

   assign unused_cmd = ^{cmd_cnt, cmd_unf};

   assign CMD_VALID  = enable & ~cmd_empty;
   assign cmd_pop    = CMD_ACK & CMD_VALID;
   assign BPI_TIMER  = timer;
   assign BPI_STATUS = status_q;

   bpi_sync_fifo_fwft #(.DW(DW), .AW(CMD_AW), .PUSH_FULL_POP(1'b1)) u_cmd_fifo (
      .CLK(CLK), .RST(RST), .clr(BPI_RST),
      .push(BPI_WE), .push_data(BPI_CMD_FIFO_DATA), .pop(cmd_pop),
      .head_data(CMD_DATA), .count(cmd_cnt), .full(cmd_full), .empty(cmd_empty),
      .ovf(cmd_ovf), .unf(cmd_unf)
   );

   // Readback full drops the push even when the port pops in the same cycle.
   bpi_sync_fifo_fwft #(.DW(DW), .AW(RBK_AW), .PUSH_FULL_POP(1'b0)) u_rbk_fifo (
      .CLK(CLK), .RST(RST), .clr(BPI_RST),
      .push(RBK_WE), .push_data(RBK_DATA), .pop(BPI_RE),
      .head_data(BPI_RBK_FIFO_DATA), .count(BPI_RBK_WRD_CNT), .full(rbk_full), .empty(rbk_empty),
      .ovf(rbk_ovf), .unf(rbk_unf)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         enable     <= 1'b0;
         cmd_ovf_st <= 1'b0;
         rbk_ovf_st <= 1'b0;
         rbk_unf_st <= 1'b0;
         timer      <= '0;
      end else if (BPI_RST) begin
         enable     <= 1'b0;
         cmd_ovf_st <= 1'b0;
         rbk_ovf_st <= 1'b0;
         rbk_unf_st <= 1'b0;
         timer      <= '0;
      end else begin
         if (BPI_DSBL)      enable <= 1'b0;
         else if (BPI_ENBL) enable <= 1'b1;
         cmd_ovf_st <= cmd_ovf_st | cmd_ovf;
         rbk_ovf_st <= rbk_ovf_st | rbk_ovf;
         rbk_unf_st <= rbk_unf_st | rbk_unf;
         if (BPI_ENBL)
            timer <= '0;
         else if (enable && (!cmd_empty || ENGINE_BUSY) && timer != TIMER_MAX)
            timer <= timer + 32'd1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         status_q           <= '0;
         status_q.cmd_empty <= 1'b1;
         status_q.rbk_empty <= 1'b1;
      end else if (BPI_RST) begin
         status_q           <= '0;
         status_q.flash_sr  <= FLASH_SR;
         status_q.busy      <= ENGINE_BUSY;
         status_q.cmd_empty <= 1'b1;
         status_q.rbk_empty <= 1'b1;
      end else begin
         status_q.flash_sr  <= FLASH_SR;
         status_q.enbl      <= enable;
         status_q.busy      <= ENGINE_BUSY;
         status_q.cmd_full  <= cmd_full;
         status_q.cmd_empty <= cmd_empty;
         status_q.rbk_full  <= rbk_full;
         status_q.rbk_empty <= rbk_empty;
         status_q.cmd_ovf   <= cmd_ovf_st;
         status_q.rbk_err   <= rbk_ovf_st | rbk_unf_st;
      end
   end
endmodule

// File: tb/tb_bpi_fifo_ctrl.sv
// Scoreboard bench for bpi_fifo_ctrl: queues hold expected FIFO contents.
module tb_bpi_fifo_ctrl;
   import bpi_pkg::*;

   logic        CLK = 1'b0, RST = 1'b1, BPI_RST = 1'b0, BPI_DSBL = 1'b0, BPI_ENBL = 1'b0;
   logic        BPI_WE = 1'b0, BPI_RE = 1'b0, CMD_ACK = 1'b0, RBK_WE = 1'b0, ENGINE_BUSY = 1'b0;
   logic [15:0] BPI_CMD_FIFO_DATA = '0, RBK_DATA = '0;
   logic [7:0]  FLASH_SR = '0;
   logic [15:0] BPI_RBK_FIFO_DATA, BPI_STATUS, CMD_DATA;
   logic [10:0] BPI_RBK_WRD_CNT;
   logic [31:0] BPI_TIMER;
   logic        CMD_VALID;

   int          errs = 0, checks = 0;
   logic [15:0] cmd_q[$], rbk_q[$];

   bpi_fifo_ctrl dut (
      .CLK(CLK), .RST(RST), .BPI_RST(BPI_RST), .BPI_DSBL(BPI_DSBL), .BPI_ENBL(BPI_ENBL),
      .BPI_WE(BPI_WE), .BPI_CMD_FIFO_DATA(BPI_CMD_FIFO_DATA), .BPI_RE(BPI_RE),
      .BPI_RBK_FIFO_DATA(BPI_RBK_FIFO_DATA), .BPI_RBK_WRD_CNT(BPI_RBK_WRD_CNT),
      .BPI_STATUS(BPI_STATUS), .BPI_TIMER(BPI_TIMER), .CMD_VALID(CMD_VALID), .CMD_DATA(CMD_DATA),
      .CMD_ACK(CMD_ACK), .RBK_WE(RBK_WE), .RBK_DATA(RBK_DATA), .ENGINE_BUSY(ENGINE_BUSY),
      .FLASH_SR(FLASH_SR)
   );

   always #12 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic cmd_push(input logic [15:0] d);
      BPI_WE = 1'b1;
      BPI_CMD_FIFO_DATA = d;
      tick;
      BPI_WE = 1'b0;
      if (cmd_q.size() < 1024) cmd_q.push_back(d);
   endtask

   task automatic cmd_pop;
      logic [15:0] e;
      chk("cmd_valid", 32'(CMD_VALID), 32'd1);
      if (cmd_q.size() > 0) begin
         e = cmd_q.pop_front();
         chk("cmd_data", 32'(CMD_DATA), 32'(e));
      end
      CMD_ACK = 1'b1;
      tick;
      CMD_ACK = 1'b0;
   endtask

   task automatic rbk_op(input logic we, input logic [15:0] d, input logic re);
      logic        full_b;
      logic [15:0] e;
      full_b = (rbk_q.size() == 1024);
      RBK_WE = we;
      RBK_DATA = d;
      BPI_RE = re;
      if (re && rbk_q.size() > 0) begin
         e = rbk_q.pop_front();
         chk("rbk_head", 32'(BPI_RBK_FIFO_DATA), 32'(e));
      end
      if (we && !full_b) rbk_q.push_back(d);
      tick;
      RBK_WE = 1'b0;
      BPI_RE = 1'b0;
      chk("rbk_cnt", 32'(BPI_RBK_WRD_CNT), 32'(rbk_q.size()));
   endtask

   initial begin
      #30 RST = 1'b0;
      chk("rst_cmd_valid", 32'(CMD_VALID), 32'd0);
      chk("rst_rbk_cnt", 32'(BPI_RBK_WRD_CNT), 32'd0);
      chk("rst_timer", BPI_TIMER, 32'd0);
      chk("rst_cmd_data", 32'(CMD_DATA), 32'd0);
      chk("rst_rbk_data", 32'(BPI_RBK_FIFO_DATA), 32'd0);
      tick;
      chk("rst_status", 32'(BPI_STATUS), 32'h0014);

      // 1: queue while disabled, then enable and drain
      cmd_push(16'h0017);
      cmd_push(16'h00FF);
      cmd_push(16'h0A5A);
      tick;
      chk("dis_cmd_valid", 32'(CMD_VALID), 32'd0);
      chk("dis_st_empty", 32'(BPI_STATUS[ST_CMD_EMPTY]), 32'd0);
      chk("dis_st_enbl", 32'(BPI_STATUS[ST_ENBL]), 32'd0);
      BPI_ENBL = 1'b1;
      tick;
      BPI_ENBL = 1'b0;
      repeat (3) cmd_pop;
      chk("drain_cmd_valid", 32'(CMD_VALID), 32'd0);

      // 2: readback push/pop/simultaneous
      for (int i = 0; i < 5; i++) rbk_op(1'b1, 16'h1000 + 16'(i), 1'b0);
      chk("rbk_head0", 32'(BPI_RBK_FIFO_DATA), 32'h1000);
      rbk_op(1'b0, 16'h0, 1'b1);
      rbk_op(1'b0, 16'h0, 1'b1);
      chk("rbk_head2", 32'(BPI_RBK_FIFO_DATA), 32'h1002);
      rbk_op(1'b1, 16'h2000, 1'b1);
      while (rbk_q.size() > 0) rbk_op(1'b0, 16'h0, 1'b1);

      // 3: command FIFO full, overflow, wrap
      for (int i = 0; i < 1024; i++) cmd_push(16'h3000 + 16'(i));
      cmd_push(16'hDEAD);
      tick;
      chk("cmd_st_full", 32'(BPI_STATUS[ST_CMD_FULL]), 32'd1);
      chk("cmd_st_ovf", 32'(BPI_STATUS[ST_CMD_OVF]), 32'd1);
      while (cmd_q.size() > 0) cmd_pop;
      chk("cmd_empty_valid", 32'(CMD_VALID), 32'd0);

      // 4: readback underflow, full, then soft reset
      rbk_op(1'b0, 16'h0, 1'b1);
      tick;
      chk("rbk_st_unf", 32'(BPI_STATUS[ST_RBK_ERR]), 32'd1);
      for (int i = 0; i < 1025; i++) rbk_op(1'b1, 16'h4000 + 16'(i), 1'b0);
      tick;
      chk("rbk_st_full", 32'(BPI_STATUS[ST_RBK_FULL]), 32'd1);
      rbk_op(1'b1, 16'hBEEF, 1'b1);
      cmd_push(16'h5555);
      FLASH_SR = 8'h5A;
      BPI_RST = 1'b1;
      BPI_ENBL = 1'b1;
      tick;
      BPI_RST = 1'b0;
      BPI_ENBL = 1'b0;
      cmd_q.delete();
      rbk_q.delete();
      chk("srst_cmd_valid", 32'(CMD_VALID), 32'd0);
      chk("srst_rbk_cnt", 32'(BPI_RBK_WRD_CNT), 32'd0);
      chk("srst_timer", BPI_TIMER, 32'd0);
      chk("srst_cmd_data", 32'(CMD_DATA), 32'd0);
      tick;
      chk("srst_status", 32'(BPI_STATUS), 32'h5A14);

      // 5: timer counts only while active
      cmd_push(16'h0101);
      cmd_push(16'h0202);
      chk("tmr_idle", BPI_TIMER, 32'd0);
      BPI_ENBL = 1'b1;
      tick;
      BPI_ENBL = 1'b0;
      chk("tmr_clr", BPI_TIMER, 32'd0);
      cmd_pop;
      cmd_pop;
      ENGINE_BUSY = 1'b1;
      repeat (100) tick;
      chk("st_busy", 32'(BPI_STATUS[ST_BUSY]), 32'd1);
      ENGINE_BUSY = 1'b0;
      repeat (5) tick;
      chk("tmr_busy", BPI_TIMER, 32'd102);
      cmd_push(16'h0303);
      cmd_push(16'h0404);
      tick;
      BPI_DSBL = 1'b1;
      tick;
      BPI_DSBL = 1'b0;
      chk("dsbl_cmd_valid", 32'(CMD_VALID), 32'd0);
      chk("dsbl_timer", BPI_TIMER, 32'd105);
      repeat (3) tick;
      chk("dsbl_timer_hold", BPI_TIMER, 32'd105);
      chk("dsbl_retained", 32'(BPI_STATUS[ST_CMD_EMPTY]), 32'd0);
      chk("dsbl_st_enbl", 32'(BPI_STATUS[ST_ENBL]), 32'd0);
      BPI_ENBL = 1'b1;
      tick;
      BPI_ENBL = 1'b0;
      chk("reenbl_timer", BPI_TIMER, 32'd0);
      cmd_pop;

      // 6: asynchronous reset mid-burst
      rbk_op(1'b1, 16'h7777, 1'b0);
      cmd_push(16'h0505);
      @(posedge CLK);
      #5 RST = 1'b1;
      #1;
      cmd_q.delete();
      rbk_q.delete();
      chk("arst_cmd_valid", 32'(CMD_VALID), 32'd0);
      chk("arst_rbk_cnt", 32'(BPI_RBK_WRD_CNT), 32'd0);
      chk("arst_timer", BPI_TIMER, 32'd0);
      chk("arst_cmd_data", 32'(CMD_DATA), 32'd0);
      chk("arst_rbk_data", 32'(BPI_RBK_FIFO_DATA), 32'd0);
      chk("arst_status", 32'(BPI_STATUS), 32'h0014);
      #3 RST = 1'b0;
      cmd_push(16'h0606);
      tick;
      chk("arst_enbl_off", 32'(CMD_VALID), 32'd0);
      chk("arst_st_enbl", 32'(BPI_STATUS[ST_ENBL]), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
